// File: rtl/req_enc8to3.sv
// Registered 8-to-3 request encoder: sticky pending capture plus a valid/ack handshake on the index.
// Define REQ_ENC_ROUND_ROBIN_EN for round-robin selection; fixed lowest-index priority otherwise.
module req_enc8to3 (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic [7:0] i_req,
    input  logic       i_ack,
    output logic [2:0] o_w,
    output logic       o_valid,
    output logic [7:0] o_pending,
    output logic       o_overflow
);

    logic [2:0] r_w;
    logic       r_valid;
    logic [7:0] r_p;
    logic       r_overflow;

    logic [7:0] w_set;
    logic       w_load;
    logic [2:0] w_sel;
    logic [7:0] w_clr;

    assign w_set  = i_req & {8{i_en}};
    // A new index may be presented when the slot is empty or being consumed this cycle.
    assign w_load = (!r_valid || i_ack) && (r_p != 8'h00);
    assign w_clr  = w_load ? (8'b0000_0001 << w_sel) : 8'h00;

`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [2:0] r_last;

    // Scan starts one past the last loaded index and wraps; reset value 7 makes the first scan start at 0.
    always_comb begin
        logic [2:0] v_idx;
        logic       v_found;
        w_sel   = 3'd0;
        v_found = 1'b0;
        v_idx   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            v_idx = r_last + 3'(k);
            if (!v_found && r_p[v_idx]) begin
                w_sel   = v_idx;
                v_found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last <= 3'b111;
        end else if (w_load) begin
            r_last <= w_sel;
        end
    end
`else
    // Descending loop so the lowest set index is the last assignment and wins.
    always_comb begin
        w_sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_p[i]) begin
                w_sel = 3'(i);
            end
        end
    end
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_w        <= 3'b000;
            r_valid    <= 1'b0;
            r_p        <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_p        <= (r_p & ~w_clr) | w_set;
            r_overflow <= r_overflow | (|(w_set & r_p & ~w_clr));
            if (w_load) begin
                r_w     <= w_sel;
                r_valid <= 1'b1;
            end else if (r_valid && i_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_w        = r_w;
    assign o_valid    = r_valid;
    assign o_pending  = r_p;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_req_enc8to3.sv
// Bench for req_enc8to3: directed test-plan sequences plus random traffic, scored against a cycle model.
module tb_req_enc8to3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [2:0] w;
    logic       valid;
    logic [7:0] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Expected post-edge outputs: {w[2:0], valid, pending[7:0], overflow}
    logic [12:0] exp_q[$];

    // Reference model state
    bit   m_p[8];
    bit   m_valid;
    int   m_w;
    bit   m_of;
    int   m_last;

    req_enc8to3 dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_en      (en),
        .i_req     (req),
        .i_ack     (ack),
        .o_w       (w),
        .o_valid   (valid),
        .o_pending (pending),
        .o_overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick_index();
        int start;
        int idx;
        start = 0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
        start = (m_last + 1) % 8;
`endif
        for (int k = 0; k < 8; k++) begin
            idx = (start + k) % 8;
            if (m_p[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [12:0] model_outputs();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_p[i];
        return {3'(m_w), m_valid, p, m_of};
    endfunction

    // Advance the model by one clock edge with the inputs that were applied.
    task automatic model_step(input bit r, input bit e, input logic [7:0] q, input bit a);
        int  any_pending;
        int  sel;
        bit  set_bits[8];
        if (r) begin
            for (int i = 0; i < 8; i++) m_p[i] = 0;
            m_valid = 0; m_w = 0; m_of = 0; m_last = 7;
            return;
        end
        any_pending = 0;
        for (int i = 0; i < 8; i++) begin
            set_bits[i] = e && q[i];
            if (m_p[i]) any_pending++;
        end
        if ((!m_valid || a) && any_pending > 0) begin
            sel = pick_index();
            m_p[sel] = 0;
            m_w = sel;
            m_valid = 1;
            m_last = sel;
        end else if (m_valid && a) begin
            m_valid = 0;
        end
        for (int i = 0; i < 8; i++) begin
            if (set_bits[i] && m_p[i]) m_of = 1;
            if (set_bits[i]) m_p[i] = 1;
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [7:0] q, input bit a);
        rst = r; en = e; req = q; ack = a;
        @(posedge clk);
        model_step(r, e, q, a);
        exp_q.push_back(model_outputs());
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Monitor: compare the DUT against each queued expectation, away from the active edge.
    always @(negedge clk) begin
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("sb_w", int'(w), int'(e[12:10]));
            check_val("sb_valid", int'(valid), int'(e[9]));
            check_val("sb_pending", int'(pending), int'(e[8:1]));
            check_val("sb_overflow", int'(overflow), int'(e[0]));
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'h00; ack = 1'b0;
        for (int i = 0; i < 8; i++) m_p[i] = 0;
        m_valid = 0; m_w = 0; m_of = 0; m_last = 7;
        #2;

        // Reset, idle
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        check_val("rst_w", int'(w), 0);
        check_val("rst_valid", int'(valid), 0);
        check_val("rst_pending", int'(pending), 0);
        check_val("rst_overflow", int'(overflow), 0);

        // Single request
        step(0, 1, 8'h20, 0);
        check_val("single_pending", int'(pending), 8'h20);
        step(0, 1, 8'h00, 0);
        check_val("single_valid", int'(valid), 1);
        check_val("single_w", int'(w), 5);
        check_val("single_pending_clr", int'(pending), 0);
        step(0, 1, 8'h00, 0);
        check_val("single_hold", int'(valid), 1);
        step(0, 1, 8'h00, 1);
        check_val("single_ack", int'(valid), 0);

        // Burst with Ack held
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h91, 0);
        step(0, 1, 8'h00, 1);
        check_val("burst_w0", int'(w), 0);
        step(0, 1, 8'h00, 1);
        check_val("burst_w1", int'(w), 4);
        step(0, 1, 8'h00, 1);
        check_val("burst_w2", int'(w), 7);
        check_val("burst_v2", int'(valid), 1);
        step(0, 1, 8'h00, 1);
        check_val("burst_empty", int'(valid), 0);

        // Fairness: serve 4, then Pending=11 picks 0 next in either build
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h10, 0);
        step(0, 1, 8'h11, 0);
        check_val("fair_w4", int'(w), 4);
        check_val("fair_pending", int'(pending), 8'h11);
        step(0, 1, 8'h00, 1);
        check_val("fair_next", int'(w), 0);

        // Overflow and disable
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h02, 0);
        check_val("ovf_pre", int'(overflow), 0);
        step(0, 1, 8'h02, 0);
        check_val("ovf_set", int'(overflow), 1);
        step(0, 0, 8'hFF, 0);
        check_val("dis_pending", int'(pending), 8'h02);
        step(0, 1, 8'h00, 1);
        step(0, 1, 8'h00, 1);
        step(0, 1, 8'h00, 1);
        check_val("ovf_sticky", int'(overflow), 1);

        // Reset mid-handshake
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h08, 0);
        step(0, 1, 8'h40, 0);
        check_val("mid_w3", int'(w), 3);
        step(1, 1, 8'h00, 1);
        check_val("mid_rst_valid", int'(valid), 0);
        check_val("mid_rst_w", int'(w), 0);
        check_val("mid_rst_pending", int'(pending), 0);

        // Same-cycle set and clear of bit 6
        step(0, 1, 8'h40, 0);
        step(0, 1, 8'h40, 0);
        check_val("same_w", int'(w), 6);
        check_val("same_pending", int'(pending), 8'h40);
        check_val("same_ovf", int'(overflow), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] rq;
            rq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) rq = 8'h00;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), rq,
                 ($urandom_range(0, 2) != 0));
        end

        step(0, 0, 8'h00, 0);
        @(negedge clk);
        @(negedge clk);
        check_val("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_enc8to3.md
Name: req_enc8to3

Overview:
Registered 8-to-3 request encoder for the simple processor.
- Captures pulsed request lines into a sticky pending register.
- Presents one pending request at a time as a 3-bit index with a valid/ack handshake.
- Serves as the encode counterpart to the 3-to-8 select decoding in the processor. Used for interrupt or bus-request sourcing into the control FSM.

Parameters:
None. Geometry is fixed: 8 request lines, 3-bit index.

Ports:
Clock     input   1  rising-edge clock
Reset     input   1  synchronous, active-high reset
En        input   1  request capture enable; when 0, Req is ignored
Req       input   8  request pulses; bit i requests index i
Ack       input   1  consumer accepts the presented index (meaningful only while Valid=1)
W         output  3  presented index (registered)
Valid     output  1  W holds an unconsumed request (registered)
Pending   output  8  pending register P (requests captured, not yet presented)
Overflow  output  1  sticky: a request was dropped because it was already pending

Behaviour:
- All state updates on the rising edge of Clock. Reset is synchronous and active-high.
- Reset values: W=3'b000, Valid=0, Pending=8'h00, Overflow=0. Reset overrides all other activity in the same cycle, including mid-handshake (Valid=1 and Ack=1); the presented index is lost.
- Definitions:
  - set = Req & {8{En}}
  - load = (!Valid || Ack) && (P != 0)
  - sel = index chosen from P (lowest set index wins in the default build)
  - clr = load ? onehot(sel) : 8'h00
- Pending update: P <= (P & ~clr) | set. When a bit is cleared and set in the same cycle, set wins and the bit stays pending.
- Output update:
  - if load: W <= sel and Valid <= 1.
  - else if Valid && Ack: Valid <= 0 and W holds its value.
  - else: W and Valid hold.
- Ack while Valid=0 is ignored and has no side effects.
- A loaded index is removed from P immediately. That bit may be re-requested while it is presented; it is then captured into P again.
- Overflow <= Overflow | (|(set & P & ~clr)). It is cleared only by Reset.
- Latency:
  - Req high in cycle t sets P at the edge ending t.
  - Valid rises at the following edge, giving 2 edges from Req to Valid when idle.
- Throughput: one index per cycle. With Ack held high and P non-empty, Valid stays 1 and W advances every cycle.
- Empty condition: if Ack is high and P=0, Valid falls at the next edge.
- No combinational path exists from Req, En or Ack to any output.

Optional Feature:
Macro: REQ_ENC_ROUND_ROBIN_EN
- Defined:
  - A 3-bit pointer L (reset 3'b111) records the last loaded index and updates to sel on every load.
  - sel is the first set bit of P scanning L+1, L+2, ... modulo 8, wrapping 7→0.
  - After reset the first scan starts at 0, so the first pick matches the fixed-priority build.
- Undefined: fixed priority, lowest index first. No pointer logic is present.
- Pending, Overflow, handshake and latency are identical in both builds.

Test Plan:
- Reset, idle: Reset=1 for 2 cycles, then Req=0 → W=0, Valid=0, Pending=00, Overflow=0.
- Single request: En=1, Req=8'h20 for 1 cycle, Ack=0 → Pending=20 after 1 edge; Valid=1, W=5, Pending=00 after the next edge; Valid holds until Ack=1 for 1 cycle, then Valid=0.
- Burst with Ack held: Req=8'h91 for 1 cycle, then Ack=1 continuously:
  - Fixed priority: W sequence 0, 4, 7 on consecutive cycles, then Valid=0.
  - Round-robin after reset: same sequence 0, 4, 7.
- Round-robin fairness (macro defined): after serving index 4, Pending=8'h11 → next W=0, since the scan runs 5, 6, 7, then wraps to 0.
- Overflow and disable:
  - Req=8'h02 twice while bit 1 is still pending (Valid busy with another index, Ack=0) → Overflow=1 and stays 1 until Reset.
  - En=0 with Req=8'hFF → Pending unchanged.
- Reset mid-operation and same-cycle set/clear:
  - Valid=1, W=3, Pending=8'h40, Ack=1 and Reset=1 in the same cycle → all outputs return to their reset values at the next edge.
  - Separately, Req bit 6 set in the same cycle that index 6 loads → Pending[6]=1 and W=6.
